flop_pipe: RTL

- Parametrised successor to the single D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline (delay line).
- Adds a per-stage valid bit, a global stall enable, a synchronous clear, a programmable reset value and an occupancy counter.
- Used wherever datapath signals must be retimed by a fixed number of cycles, with bubbles tracked.

---
 rtl/flop_pipe_pkg.sv | 11 +
 rtl/flop_en_r.sv | 30 +++
 rtl/flop_pipe.sv | 95 +++++++++
 3 files changed

// File: rtl/flop_pipe_pkg.sv
// Shared constants and helpers for the flop_pipe register pipeline.
package flop_pipe_pkg;

    localparam int MAX_DEPTH = 64;

    // Bits needed to hold an occupancy of 0..depth.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flop_en_r.sv
// One pipeline stage: register with async active-high reset, sync clear,
// enable and a programmable reset value.
module flop_en_r #(
    parameter int           W         = 9,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // NOTE: non-blocking assignment, so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VAL;
        end else if (clr_i) begin
            data_q <= RESET_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/flop_pipe.sv
// WIDTH x DEPTH delay line with per-stage valid, stall, clear and occupancy count.
// Define FLOP_PIPE_TAP_EN to expose every stage on tap_data/tap_valid.
module flop_pipe
    import flop_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      clr,
    input  logic [WIDTH-1:0]          d,
    input  logic                      d_valid,
    output logic [WIDTH-1:0]          q,
    output logic                      q_valid,
    output logic [count_w(DEPTH)-1:0] count,
    output logic                      empty,
    output logic                      full
`ifdef FLOP_PIPE_TAP_EN
    ,
    output logic [DEPTH*WIDTH-1:0]    tap_data,
    output logic [DEPTH-1:0]          tap_valid
`endif
);

    localparam int            CW      = count_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("flop_pipe: DEPTH out of range 1..64");
    end

    // Each stage is {valid, data}; stage DEPTH-1 drives the outputs.
    logic [WIDTH:0] stage_q [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH:0] stage_d;

        if (i == 0) begin : g_head
            assign stage_d = {d_valid, d};
        end else begin : g_body
            assign stage_d = stage_q[i-1];
        end

        flop_en_r #(
            .W         (WIDTH + 1),
            .RESET_VAL ({1'b0, RESET_VAL})
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .clr_i (clr),
            .en_i  (en),
            .d_i   (stage_d),
            .q_o   (stage_q[i])
        );

`ifdef FLOP_PIPE_TAP_EN
        assign tap_data[i*WIDTH +: WIDTH] = stage_q[i][WIDTH-1:0];
        assign tap_valid[i]               = stage_q[i][WIDTH];
`else
`endif
    end

    assign q       = stage_q[DEPTH-1][WIDTH-1:0];
    assign q_valid = stage_q[DEPTH-1][WIDTH];

    logic [CW-1:0] count_q, count_d;

    // NOTE: default assigned first so no path through this block infers a latch.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(d_valid) - CW'(q_valid);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    a_count_range: assert property (@(posedge clk) disable iff (reset) count_q <= DEPTH_C);

endmodule
